// File: rtl/global_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map, STATUS bit
// positions and the transmit FSM states (PARITY exists only with UART_TX_PARITY_EN).
package global_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic slave bus bundle for the UART transmitter.
interface wb_uart_tx_if;

  logic        CYC;
  logic        STB;
  logic        WE;
  logic [31:0] ADR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;

  modport master (
    output CYC, STB, WE, ADR, DAT_I,
    input  DAT_O, ACK
  );

  modport slave (
    input  CYC, STB, WE, ADR, DAT_I,
    output DAT_O, ACK
  );

endinterface

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle. Head entry is visible on dout without a read cycle.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped UART transmitter: TXDATA/STATUS/DIVISOR registers, TX FIFO and
// an 8N1 serialiser (8E1 with an extra parity bit when UART_TX_PARITY_EN is defined).
module wb_uart_tx
  import global_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  wb_uart_tx_if.slave bus,
  output logic        tx
);

  logic        ack_reg;
  logic [31:0] dat_o_reg;
  logic [15:0] div_reg;
  logic        ovf_reg;

  logic        access;
  logic [1:0]  reg_sel;
  logic        wr_txdata;
  logic        wr_div;
  logic        rd_status;
  logic        push_drop;
  logic [3:0]  status_bits;
  logic [31:0] rd_data;
  logic        busy;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  tx_state_t   state_reg, state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [15:0] bit_div_reg, bit_div_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        bit_done;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.ADR[31:4], bus.ADR[1:0], bus.DAT_I[31:16]};

  // A transfer is taken only in a cycle where no ACK is outstanding.
  assign access    = bus.CYC & bus.STB & ~ack_reg;
  assign reg_sel   = bus.ADR[3:2];
  assign wr_txdata = access & bus.WE  & (reg_sel == REG_TXDATA);
  assign wr_div    = access & bus.WE  & (reg_sel == REG_DIVISOR);
  assign rd_status = access & ~bus.WE & (reg_sel == REG_STATUS);
  assign push_drop = wr_txdata & fifo_full & ~fifo_pop;
  assign busy      = (state_reg != ST_IDLE);

  always_comb begin
    status_bits            = '0;
    status_bits[STAT_FULL]  = fifo_full;
    status_bits[STAT_EMPTY] = fifo_empty;
    status_bits[STAT_BUSY]  = busy;
    status_bits[STAT_OVF]   = ovf_reg;
  end

  always_comb begin
    rd_data = '0;
    if (!bus.WE) begin
      case (reg_sel)
        REG_STATUS:  rd_data = {28'b0, status_bits};
        REG_DIVISOR: rd_data = {16'b0, div_reg};
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
      ovf_reg   <= 1'b0;
      div_reg   <= 16'(DEFAULT_DIV);
    end else begin
      ack_reg   <= access;
      dat_o_reg <= access ? rd_data : 32'd0;
      if (wr_div) begin
        div_reg <= clamp_div(bus.DAT_I[15:0]);
      end
      // A dropped byte wins over the clear-on-read of STATUS.
      if (push_drop) begin
        ovf_reg <= 1'b1;
      end else if (rd_status) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign bus.ACK   = ack_reg;
  assign bus.DAT_O = dat_o_reg;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .din   (bus.DAT_I[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_cnt_reg == bit_div_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_div_reg  <= 16'(DEFAULT_DIV);
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_div_reg  <= bit_div_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg + 16'd1;
    bit_div_next  = bit_div_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    fifo_pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        baud_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          bit_div_next = div_reg;
          state_next   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^fifo_dout;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = ST_PARITY;
`else
            state_next   = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A divisor change is picked up only when a new bit period begins.
    if ((state_reg != ST_IDLE) && bit_done) begin
      baud_cnt_next = '0;
      bit_div_next  = div_reg;
    end
  end

  // The line level is computed from the next state so tx changes with the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register access, ACK handshake, frame timing,
// FIFO overflow and mid-frame reset; parity frame when UART_TX_PARITY_EN is defined.
module tb_wb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  int n_checks = 0;
  int n_errors = 0;

  wb_uart_tx_if bus ();

  wb_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (434)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int n;
    @(negedge clk);
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we; bus.ADR = adr; bus.DAT_I = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.ACK !== 1'b1 && n < 10);
    chk("bus_ack", 32'(bus.ACK), 32'd1);
    rdata = bus.DAT_O;
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
    $display("wb %s adr=0x%0h wdata=0x%0h rdata=0x%0h", we ? "wr" : "rd", adr, wdata, rdata);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_xfer(1'b1, adr, wdata, dummy);
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(1'b0, adr, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  // Waits for a start bit; returns with the caller at the first negedge where tx is low.
  task automatic wait_start(input string tag);
    int n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx), 32'd0);
  endtask

  // Divisor 4: samples the middle of each bit period.
  task automatic recv_byte(output logic [7:0] d);
    d = 8'h00;
    wait_start("rx_start_seen");
    repeat (2) @(negedge clk);
    chk("rx_start_mid", 32'(tx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk);
      d[k] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (4) @(negedge clk);
    chk("rx_parity", 32'(tx), 32'(^d));
`endif
    repeat (4) @(negedge clk);
    chk("rx_stop", 32'(tx), 32'd1);
  endtask

  // Checks the line every clock against a frame pattern (bit 0 sent first), 4 clocks per bit.
  task automatic frame_chk(input string tag, input logic [7:0] data, input logic [10:0] pattern,
                           input int nbits);
    wb_write(32'h0, {24'd0, data});
    wait_start({tag, "_start"});
    for (int i = 0; i < nbits * 4; i++) begin
      chk(tag, 32'(tx), 32'(pattern[i / 4]));
      @(negedge clk);
    end
    chk({tag, "_idle"}, 32'(tx), 32'd1);
  endtask

  logic [7:0]  rx_q [$];
  logic [7:0]  rx_b;
  logic [31:0] rd;
  int          low_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.ADR = '0; bus.DAT_I = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ACK), 32'd0);
    chk("rst_dat_o", bus.DAT_O, 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    wb_read_chk("status_reset", 32'h4, 32'h2);
    chk("tx_idle", 32'(tx), 32'd1);
    wb_read_chk("div_reset", 32'h8, 32'd434);

    // Divisor clamp and readback
    wb_write(32'h8, 32'd1);
    wb_read_chk("div_clamp1", 32'h8, 32'd2);
    wb_write(32'h8, 32'd0);
    wb_read_chk("div_clamp0", 32'h8, 32'd2);
    wb_write(32'h8, 32'hABCD_0004);
    wb_read_chk("div_4", 32'h8, 32'd4);

    // Reserved offset and TXDATA read
    wb_write(32'hC, 32'hDEAD_BEEF);
    wb_read_chk("rsvd_read", 32'hC, 32'd0);
    wb_read_chk("txdata_read", 32'h0, 32'd0);
    wb_read_chk("status_no_push", 32'h4, 32'h2);

    // No ACK unless both CYC and STB are high
    @(negedge clk);
    bus.CYC = 1'b0; bus.STB = 1'b1; bus.ADR = 32'h4;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_ack_cyc_low", 32'(bus.ACK), 32'd0);
    end
    bus.CYC = 1'b1; bus.STB = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_ack_stb_low", 32'(bus.ACK), 32'd0);
    end
    bus.CYC = 1'b0;

    // Held strobe: ACK on alternate cycles only
    @(negedge clk);
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0; bus.ADR = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("ack_hold", 32'(bus.ACK), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("ack_hold_data", bus.DAT_O, 32'h2);
    end
    bus.CYC = 1'b0; bus.STB = 1'b0;
    @(posedge clk); #1;
    chk("ack_released", 32'(bus.ACK), 32'd0);

    // Single frame 0x55, divisor 4
`ifdef UART_TX_PARITY_EN
    frame_chk("frame_55", 8'h55, 11'h4AA, 11);
`else
    frame_chk("frame_55", 8'h55, 11'h2AA, 10);
`endif
    wb_read_chk("status_after_55", 32'h4, 32'h2);

`ifdef UART_TX_PARITY_EN
    frame_chk("frame_07_par", 8'h07, 11'h60E, 11);
    wb_read_chk("status_after_07", 32'h4, 32'h2);
`endif

    // Overflow: a lead frame keeps the transmitter busy while 9 bytes are queued
    wb_write(32'h0, 32'hA5);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          wb_write(32'h0, 32'h10 + 32'(i));
        end
        wb_read_chk("status_ovf", 32'h4, 32'hD);
        wb_read_chk("status_ovf_clr", 32'h4, 32'h5);
      end
      begin
        for (int f = 0; f < 9; f++) begin
          recv_byte(rx_b);
          rx_q.push_back(rx_b);
        end
      end
    join
    chk("rx_count", 32'(rx_q.size()), 32'd9);
    if (rx_q.size() == 9) begin
      chk("rx_lead", 32'(rx_q[0]), 32'hA5);
      for (int i = 1; i < 9; i++) begin
        chk("rx_byte", 32'(rx_q[i]), 32'h10 + 32'(i - 1));
      end
    end
    low_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx === 1'b0) low_cnt++;
    end
    chk("ninth_dropped", 32'(low_cnt), 32'd0);
    wb_read_chk("status_drained", 32'h4, 32'h2);

    // Reset in the middle of the data bits of 0x00
    wb_write(32'h0, 32'h00);
    wait_start("rst_frame_start");
    repeat (10) @(negedge clk);
    chk("tx_mid_data", 32'(tx), 32'd0);
    rst = 1'b1;
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0; bus.ADR = 32'h4;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_ack", 32'(bus.ACK), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.CYC = 1'b0; bus.STB = 1'b0;
    wb_read_chk("status_after_rst", 32'h4, 32'h2);
    wb_read_chk("div_after_rst", 32'h8, 32'd434);
    repeat (20) @(negedge clk);
    chk("tx_idle_after_rst", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DEFAULT_DIV, default 434, reset value of the baud divisor (clocks per bit).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port CYC  in  1  Wishbone bus cycle.
REQ-006 SHALL have port STB  in  1  Wishbone strobe; this slave is selected.
REQ-007 SHALL have port WE  in  1  write enable.
REQ-008 SHALL have port ADR  in  32  byte address; only ADR[3:2] decoded.
REQ-009 SHALL have port DAT_I  in  32  write data from master.
REQ-010 SHALL have port DAT_O  out  32  read data to master.
REQ-011 SHALL have port ACK  out  1  Wishbone acknowledge.
REQ-012 SHALL have port tx  out  1  serial line, idle high.

Function
REQ-013 SHALL decode ADR[3:2]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
REQ-014 SHALL assert ACK for exactly one cycle, registered, in the cycle after CYC&STB is first seen high with ACK low; no ACK while CYC or STB is low.
REQ-015 SHALL NOT acknowledge a transfer twice: ACK is held low in the cycle after an ACK even if CYC&STB stays high.
REQ-016 SHALL push DAT_I[7:0] into the FIFO on an acknowledged TXDATA write; a read of TXDATA returns 0.
REQ-017 SHALL return STATUS as {28'b0, overflow, busy, empty, full} (bit0 full, bit1 empty, bit2 busy, bit3 overflow), valid with ACK.
REQ-018 SHALL drop the byte of a TXDATA write while the FIFO is full, still ACK it, and set sticky overflow.
REQ-019 SHALL clear overflow on an acknowledged STATUS read; if an overflow write coincides, it stays set.
REQ-020 SHALL accept a push into a full FIFO when the transmitter pops in the same cycle (count unchanged, no overflow).
REQ-021 SHALL load DIVISOR from DAT_I[15:0] on write, clamp values below 2 to 2, and read back the clamped value; the new value takes effect at the next bit boundary.
REQ-022 SHALL ignore writes to reserved offset 3 and return 0 on reads.
REQ-023 SHALL run FSM IDLE -> START -> DATA -> STOP -> IDLE; each bit state lasts exactly DIVISOR clocks.
REQ-024 IDLE: tx=1; when FIFO non-empty, pop and load the shift register, next state START.
REQ-025 START: tx=0. DATA: 8 bits, LSB first. STOP: tx=1, then IDLE (minimum one IDLE cycle between frames).
REQ-026 busy SHALL be 1 in every state other than IDLE.
REQ-027 tx SHALL be driven from a register (glitch-free).

Reset
REQ-028 On rst: ACK=0, DAT_O=0, tx=1, state IDLE, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, bit and baud counters 0.
REQ-029 rst mid-frame SHALL abort the frame: tx=1 from the next cycle; any ACK pending is dropped.

Configuration
REQ-030 With UART_TX_PARITY_EN defined, a PARITY state SHALL be inserted between DATA and STOP, sending the even parity (XOR of the 8 data bits) for DIVISOR clocks; the frame is 11 bits.
REQ-031 Without UART_TX_PARITY_EN the frame SHALL be 10 bits with no parity state or logic.

Structure
REQ-032 global_pkg SHALL hold the register offset constants, the STATUS bit indices and the FSM state enum type.
REQ-033 The FIFO SHALL be a separate sub-module tx_fifo (sync, one clock, push/pop/full/empty, same-cycle push+pop when full).

Verification
REQ-034 Reset, then read STATUS -> DAT_O=0x2 (empty), tx=1, DIVISOR reads 434.
REQ-035 DIVISOR=4, write TXDATA 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clocks (40 clocks total), busy=0 afterwards.
REQ-036 DIVISOR=4, write 9 bytes back-to-back with FIFO_DEPTH=8 -> STATUS bit0 and bit3 set; 9th byte never transmitted; next STATUS read shows bit3=0.
REQ-037 CYC&STB held high for 5 cycles on a STATUS read -> ACK pulses high on alternate cycles, never on two consecutive cycles.
REQ-038 Write DIVISOR=1 -> reads back 2; assert rst mid-DATA -> tx=1 next cycle, STATUS=0x2.
REQ-039 With UART_TX_PARITY_EN defined, DIVISOR=4, send 0x07 -> parity bit 1 after bit7, stop bit follows; 44 clocks per frame.
